// File: rtl/axi_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO controller slice.
// The watermark option is selected by the AXI_FIFO_CTRL_WATERMARK_EN macro in axi_fifo_ctrl.
package axi_fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 5;
    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0] cnt_t;

    typedef enum logic {
        OS_EMPTY = 1'b0,
        OS_VALID = 1'b1
    } os_state_t;

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping FIFO pointer: increment-enable, synchronous clear, asynchronous active-low reset.
module fifo_ptr_ctr
    import axi_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_ADDR_WIDTH + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ptr <= '0;
        end else if (i_clr) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            o_ptr <= o_ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi_fifo_ctrl.sv
// Flow-control sequencer for the single-clock FIFO: handshakes -> memory enables/addresses, count, flags.
// Optional watermark flags are built when AXI_FIFO_CTRL_WATERMARK_EN is defined; otherwise tied low.
module axi_fifo_ctrl
    import axi_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = 28,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH:0] cnt_w_t;

    localparam cnt_w_t DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    cnt_w_t    wr_ptr;
    cnt_w_t    rd_ptr;
    cnt_w_t    mem_cnt;
    cnt_w_t    mem_cnt_next;
    logic      full_q;
    logic      slot_free;
    os_state_t state_q;
    os_state_t state_d;

    fifo_ptr_ctr #(.WIDTH(CW)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_inc   (o_mem_wr_en),
        .o_ptr   (wr_ptr)
    );

    fifo_ptr_ctr #(.WIDTH(CW)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_inc   (o_mem_rd_en),
        .o_ptr   (rd_ptr)
    );

    assign mem_cnt       = wr_ptr - rd_ptr;
    assign o_mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign o_mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // s_ready comes only from the registered full flag: a pop never opens it combinationally.
    assign o_s_ready = !full_q;
    assign o_full    = full_q;

    // A write presented during flush is dropped along with the contents.
    assign o_mem_wr_en = i_s_valid & o_s_ready & !i_flush;

    assign o_m_valid   = (state_q == OS_VALID);
    assign slot_free   = !o_m_valid | i_m_ready;
    assign o_mem_rd_en = (mem_cnt != '0) & slot_free & !i_flush;

    assign mem_cnt_next = i_flush ? '0
                        : mem_cnt + cnt_w_t'(o_mem_wr_en) - cnt_w_t'(o_mem_rd_en);

    assign o_count = mem_cnt + cnt_w_t'(o_m_valid);
    assign o_empty = (o_count == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= OS_EMPTY;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= (mem_cnt_next == DEPTH_CNT);
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = OS_EMPTY;
        end else begin
            case (state_q)
                OS_EMPTY: if (o_mem_rd_en) state_d = OS_VALID;
                OS_VALID: if (i_m_ready)   state_d = o_mem_rd_en ? OS_VALID : OS_EMPTY;
                default:                   state_d = OS_EMPTY;
            endcase
        end
    end

`ifdef AXI_FIFO_CTRL_WATERMARK_EN
    localparam cnt_w_t AF_CNT = cnt_w_t'(AF_LEVEL);
    localparam cnt_w_t AE_CNT = cnt_w_t'(AE_LEVEL);

    cnt_w_t count_next;
    logic   af_q;
    logic   ae_q;

    assign count_next = mem_cnt_next + cnt_w_t'(state_d == OS_VALID);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= (count_next >= AF_CNT);
            ae_q <= (count_next <= AE_CNT);
        end
    end

    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
`else
    // Levels are referenced only so they stay live; the flags are constant low.
    assign o_almost_full  = 1'b0 & (AF_LEVEL != 0);
    assign o_almost_empty = 1'b0 & (AE_LEVEL != 0);
`endif

endmodule

// File: tb/tb_axi_fifo_ctrl.sv
// Self-checking bench for axi_fifo_ctrl: vector table, fill/flush/reset sequences, memory model + scoreboard.
module tb_axi_fifo_ctrl;
    import axi_fifo_pkg::*;

    localparam int AW = FIFO_ADDR_WIDTH;
    localparam int DW = FIFO_DATA_WIDTH;
`ifdef AXI_FIFO_CTRL_WATERMARK_EN
    localparam bit WM_ON = 1'b1;
`else
    localparam bit WM_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    cnt_t          count;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;

    axi_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_s_valid      (s_valid),
        .o_s_ready      (s_ready),
        .o_m_valid      (m_valid),
        .i_m_ready      (m_ready),
        .o_mem_wr_en    (wr_en),
        .o_mem_wr_addr  (wr_addr),
        .o_mem_rd_en    (rd_en),
        .o_mem_rd_addr  (rd_addr),
        .o_count        (count),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_af(input int c);
        return (WM_ON && c >= 28) ? 1 : 0;
    endfunction

    function automatic int exp_ae(input int c);
        return (WM_ON && c <= 4) ? 1 : 0;
    endfunction

    // Behavioural fifo_memory (registered read) plus in-order scoreboard.
    logic [DW-1:0] mem_m [0:FIFO_DEPTH-1];
    logic [DW-1:0] rd_data;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] head;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] last_wr_addr = '0;
    int            wr_total = 0;
    int            rd_total = 0;
    bit            saw_wrap = 1'b0;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    head = exp_q.pop_front();
                    chk("sb_data", int'(rd_data), int'(head));
                    rd_total++;
                end
            end
            if (rd_en) rd_data = mem_m[rd_addr];
            if (wr_en) begin
                mem_m[wr_addr] = wdata;
                exp_q.push_back(wdata);
                if (wr_addr == '0 && last_wr_addr == AW'(FIFO_DEPTH - 1)) saw_wrap = 1'b1;
                last_wr_addr = wr_addr;
                wdata = wdata + 1'b1;
                wr_total++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int limit);
        int cyc;
        cyc = 0;
        while (!empty && cyc < limit) begin
            tick();
            cyc++;
        end
        chk(name, int'(empty), 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"},   int'(count),   0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_empty"},   int'(empty),   1);
        chk({tag, "_s_ready"}, int'(s_ready), 1);
        chk({tag, "_full"},    int'(full),    0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_afull"},   int'(afull),   0);
        chk({tag, "_aempty"},  int'(aempty),  exp_ae(0));
    endtask

    typedef struct {
        logic sv;
        logic mr;
        logic exp_rd_en;
        int   exp_count;
        logic exp_mv;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int target;
        int guard;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 2, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b0};

        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // Vector table: single word latency, stall, pop+fetch, no bypass, steady stream.
        for (int i = 0; i < 12; i++) begin
            s_valid = tbl[i].sv;
            m_ready = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d_wr_en", i), int'(wr_en), int'(tbl[i].sv));
            chk($sformatf("tbl%0d_rd_en", i), int'(rd_en), int'(tbl[i].exp_rd_en));
            if (i == 0) chk("tbl0_wr_addr", int'(wr_addr), 0);
            tick();
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
            chk($sformatf("tbl%0d_m_valid", i), int'(m_valid), int'(tbl[i].exp_mv));
            chk($sformatf("tbl%0d_empty", i), int'(empty), (tbl[i].exp_count == 0) ? 1 : 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Fill to DEPTH+1 with the consumer stalled.
        for (int k = 1; k <= 33; k++) begin
            s_valid = 1'b1;
            #1;
            chk($sformatf("fill%0d_wr_en", k), int'(wr_en), 1);
            tick();
            chk($sformatf("fill%0d_count", k), int'(count), k);
            chk($sformatf("fill%0d_full", k), int'(full), (k == 33) ? 1 : 0);
            chk($sformatf("fill%0d_afull", k), int'(afull), exp_af(k));
            chk($sformatf("fill%0d_aempty", k), int'(aempty), exp_ae(k));
        end
        #1;
        chk("full_wr_en", int'(wr_en), 0);
        chk("full_s_ready", int'(s_ready), 0);
        tick();
        chk("full_drop_count", int'(count), 33);

        m_ready = 1'b1;
        #1;
        chk("pop_rd_en", int'(rd_en), 1);
        chk("pop_wr_en", int'(wr_en), 0);
        chk("pop_s_ready_same_cycle", int'(s_ready), 0);
        tick();
        chk("pop_s_ready_next", int'(s_ready), 1);
        chk("pop_full", int'(full), 0);
        chk("pop_count", int'(count), 32);
        s_valid = 1'b0;
        wait_empty("fill_drain", 100);

        // Random stream across several pointer wraps.
        target = wr_total + 100;
        guard  = 0;
        while (wr_total < target && guard < 3000) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        chk("stream_budget", (guard < 3000) ? 1 : 0, 1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_empty("stream_drain", 200);
        tick();
        chk("stream_no_loss", rd_total, wr_total);
        chk("stream_queue_empty", exp_q.size(), 0);
        chk("addr_wrapped", int'(saw_wrap), 1);

        // Flush with ten words held and a write presented.
        m_ready = 1'b0;
        s_valid = 1'b1;
        repeat (10) tick();
        chk("preflush_count", int'(count), 10);
        flush = 1'b1;
        #1;
        chk("flush_wr_en", int'(wr_en), 0);
        chk("flush_rd_en", int'(rd_en), 0);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk_idle("flush");

        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("postflush_count", int'(count), 1);
        chk("postflush_m_valid_n1", int'(m_valid), 0);
        tick();
        chk("postflush_m_valid_n2", int'(m_valid), 1);
        m_ready = 1'b1;
        wait_empty("postflush_drain", 20);

        // Asynchronous reset in the middle of traffic.
        m_ready = 1'b0;
        s_valid = 1'b1;
        repeat (5) tick();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("after_reset_count", int'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
